// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the direct-mapped cache miss-handling logic.
// Block geometry is 8 words of 16 bits, so a block covers 16 bytes of address space.
package cache_pkg;

  localparam int DEFAULT_ADDR_W  = 16;
  localparam int DEFAULT_DATA_W  = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int WORD_SEL_W      = $clog2(WORDS_PER_BLOCK);
  localparam int BLOCK_OFFSET_W  = WORD_SEL_W + 1;
  // One extra bit so the request counter can hold WORDS_PER_BLOCK itself
  localparam int CNT_W           = WORD_SEL_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/cache_fill_counter.sv
// Word counter used by the fill controller: synchronous clear, count enable,
// and a flag raised while the count equals TERMINAL.
module cache_fill_counter #(
  parameter int CNT_W    = 4,
  parameter int TERMINAL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == CNT_W'(TERMINAL));

endmodule

// File: rtl/cache_fill_controller.sv
// Miss-handling FSM: on a miss, requests every word of the block from memory, writes each
// returned word into the data array and writes the tag together with the final word.
module cache_fill_controller
  import cache_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [DATA_W-1:0] memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_enable,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] cache_address,
  output logic [DATA_W-1:0] cache_data
);

  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'((1 << BLOCK_OFFSET_W) - 1);

  fill_state_e       state;
  fill_state_e       next_state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  req_cnt;
  logic [CNT_W-1:0]  rcv_cnt;
  logic              req_done;
  logic              rcv_last;
  logic              start_fill;
  logic              req_en;
  logic              rcv_en;

  cache_fill_counter #(
    .CNT_W   (CNT_W),
    .TERMINAL(WORDS_PER_BLOCK)
  ) u_req_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_fill),
    .enable  (req_en),
    .count   (req_cnt),
    .terminal(req_done)
  );

  cache_fill_counter #(
    .CNT_W   (CNT_W),
    .TERMINAL(WORDS_PER_BLOCK - 1)
  ) u_rcv_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_fill),
    .enable  (rcv_en),
    .count   (rcv_cnt),
    .terminal(rcv_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Base low bits are forced to zero, so OR-ing the word offset never carries out of the block
  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '0;
    end else if (start_fill) begin
      base <= miss_address & BLOCK_MASK;
    end
  end

  always_comb begin
    next_state       = state;
    start_fill       = 1'b0;
    req_en           = 1'b0;
    rcv_en           = 1'b0;
    fsm_busy         = 1'b0;
    memory_enable    = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    cache_address    = '0;
    cache_data       = '0;
    case (state)
      IDLE: begin
        if (miss_detected) begin
          start_fill = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (!req_done) begin
          memory_enable  = 1'b1;
          memory_address = base | (ADDR_W'(req_cnt) << 1);
          req_en         = 1'b1;
        end
        // Returns may arrive while requests are still being issued
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          cache_address    = base | (ADDR_W'(rcv_cnt) << 1);
          cache_data       = memory_data;
          rcv_en           = 1'b1;
          if (rcv_last) begin
            write_tag_array = 1'b1;
            next_state      = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_controller.sv
// Self-checking bench for cache_fill_controller: pipelined memory model plus a
// transaction-level reference of the fill sequence, directed and random stimulus.
module tb_cache_fill_controller;

  localparam int L = 4;
  localparam int NW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic [15:0] memory_data = '0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy;
  logic        memory_enable;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] cache_address;
  logic [15:0] cache_data;

  cache_fill_controller dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .memory_data      (memory_data),
    .memory_data_valid(memory_data_valid),
    .fsm_busy         (fsm_busy),
    .memory_enable    (memory_enable),
    .memory_address   (memory_address),
    .write_data_array (write_data_array),
    .write_tag_array  (write_tag_array),
    .cache_address    (cache_address),
    .cache_data       (cache_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Memory model: in-order returns, each due L cycles after its request plus optional stall
  logic [15:0] q_addr[$];
  int          q_due[$];
  int          last_due = -1000;
  int          stall_mode = 0;

  // Reference: one fill = NW requests on consecutive cycles, NW writes on returned words
  bit          model_ok = 0;
  bit          m_busy = 0;
  logic [15:0] m_base = '0;
  int          m_issued = 0;
  int          m_got = 0;

  bit mark_next = 0;
  int t0 = 0;
  int first_req = -1;
  int tag_cyc = -1;
  int last_busy = -1;
  int nwrites = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, want %h", tag, cyc, actual, expected);
    end
  endtask

  task automatic check_cycle();
    logic        e_men, e_wr, e_tag;
    logic [15:0] e_maddr, e_caddr, e_cdata;
    e_men   = m_busy && (m_issued < NW);
    e_maddr = e_men ? m_base + 16'(2 * m_issued) : 16'h0;
    e_wr    = m_busy && memory_data_valid;
    e_caddr = e_wr ? m_base + 16'(2 * m_got) : 16'h0;
    e_cdata = e_wr ? memory_data : 16'h0;
    e_tag   = e_wr && (m_got == NW - 1);
    check_output("busy",       32'(fsm_busy),         32'(m_busy));
    check_output("mem_en",     32'(memory_enable),    32'(e_men));
    check_output("mem_addr",   32'(memory_address),   32'(e_maddr));
    check_output("wr_data",    32'(write_data_array), 32'(e_wr));
    check_output("wr_tag",     32'(write_tag_array),  32'(e_tag));
    check_output("cache_addr", 32'(cache_address),    32'(e_caddr));
    check_output("cache_data", 32'(cache_data),       32'(e_cdata));
  endtask

  task automatic apply_stimulus(input bit r, input bit miss, input logic [15:0] addr, input bit spur);
    int extra;
    int due;
    @(posedge clk);
    #1;
    if (mark_next) begin
      t0 = cyc; first_req = -1; tag_cyc = -1; last_busy = -1; nwrites = 0;
      mark_next = 0;
    end
    rst = r;
    miss_detected = miss;
    miss_address = addr;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      memory_data_valid = 1'b1;
      memory_data = mem_word(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      memory_data_valid = spur;
      memory_data = 16'($urandom);
    end
    @(negedge clk);
    if (model_ok) check_cycle();
    if (memory_enable === 1'b1) begin
      case (stall_mode)
        1: extra = 2 * ((int'(memory_address[3:1]) + 1) / 3);
        2: extra = int'($urandom_range(0, 3));
        default: extra = 0;
      endcase
      due = cyc + L + extra;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      q_addr.push_back(memory_address);
      q_due.push_back(due);
      if (first_req < 0) first_req = cyc - t0;
    end
    if (write_tag_array === 1'b1) tag_cyc = cyc - t0;
    if (write_data_array === 1'b1) nwrites++;
    if (fsm_busy === 1'b1) last_busy = cyc - t0;
    if (r) begin
      model_ok = 1; m_busy = 0; m_base = '0; m_issued = 0; m_got = 0;
    end else if (model_ok) begin
      if (!m_busy) begin
        if (miss) begin
          m_busy = 1; m_base = addr & 16'hFFF0; m_issued = 0; m_got = 0;
        end
      end else begin
        if (m_issued < NW) m_issued++;
        if (memory_data_valid) begin
          m_got++;
          if (m_got == NW) m_busy = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 16'h0, 0);
  endtask

  initial begin
    apply_stimulus(1, 0, 16'h0, 0);
    apply_stimulus(1, 0, 16'h0, 0);
    idle(2);

    // Basic fill with a second miss ignored mid-fill
    stall_mode = 0;
    mark_next = 1;
    apply_stimulus(0, 1, 16'h1236, 0);
    idle(2);
    apply_stimulus(0, 1, 16'h4000, 0);
    idle(11);
    check_output("t1_first_req", 32'(first_req), 32'd1);
    check_output("t1_tag_cycle", 32'(tag_cyc), 32'd12);
    check_output("t1_last_busy", 32'(last_busy), 32'd12);
    check_output("t1_writes", 32'(nwrites), 32'd8);
    idle(2);

    // Top-of-memory block
    mark_next = 1;
    apply_stimulus(0, 1, 16'hFFFE, 0);
    idle(14);
    check_output("t3_tag_cycle", 32'(tag_cyc), 32'd12);
    check_output("t3_writes", 32'(nwrites), 32'd8);

    // Reset in cycle 6 of a fill, then a clean fill
    apply_stimulus(0, 1, 16'h0A5A, 0);
    idle(5);
    apply_stimulus(1, 0, 16'h0, 0);
    mark_next = 1;
    idle(7);
    check_output("t4_stale_writes", 32'(nwrites), 32'd0);
    check_output("t4_stale_busy", 32'(last_busy), 32'hFFFF_FFFF);
    mark_next = 1;
    apply_stimulus(0, 1, 16'h0020, 0);
    idle(14);
    check_output("t4_tag_cycle", 32'(tag_cyc), 32'd12);
    check_output("t4_writes", 32'(nwrites), 32'd8);

    // Stalled returns: valids in 5,6,9,10,11,14,15,16
    stall_mode = 1;
    mark_next = 1;
    apply_stimulus(0, 1, 16'h2468, 0);
    idle(18);
    check_output("t5_tag_cycle", 32'(tag_cyc), 32'd16);
    check_output("t5_writes", 32'(nwrites), 32'd8);

    // Spurious valids while idle
    mark_next = 1;
    for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 16'h0, 1);
    check_output("t6_writes", 32'(nwrites), 32'd0);
    check_output("t6_busy", 32'(last_busy), 32'hFFFF_FFFF);

    // Random traffic against the reference
    stall_mode = 2;
    for (int i = 0; i < 400; i++) begin
      bit r, m, s;
      r = ($urandom_range(0, 63) == 0);
      m = ($urandom_range(0, 5) == 0);
      s = !m_busy && (q_due.size() == 0) && ($urandom_range(0, 7) == 0);
      apply_stimulus(r, m, 16'($urandom), s);
    end
    idle(30);
    check_output("drain_busy", 32'(fsm_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
